// File: rtl/ram_arbiter.sv
// ----------------------------------------------------------------------------
// ram_arbiter
//
// Shares one port of a dual-port RAM between REQS requesters. Arbitration
// is round-robin, starting after the last owner. The owner may hold the port
// for up to MAX_BURST consecutive grants by keeping its lock hint high. Reads
// return one cycle after the grant. The strobe is rvalid, and the data on
// rdata comes straight from the RAM's registered output.
//
// Parameters
//   DATA      : RAM word width in bits
//   ADDR      : RAM address width in bits
//   REQS      : number of requesters (2..8)
//   MAX_BURST : maximum consecutive locked grants (1..15)
//
// Ports
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low reset
//   req      : per-requester request, held until granted
//   lock     : per-requester burst-lock hint (only meaningful with req)
//   wr       : per-requester write flag (1 = write, 0 = read)
//   addr     : flattened addresses, requester i at [i*ADDR +: ADDR]
//   din      : flattened write data, requester i at [i*DATA +: DATA]
//   gnt      : combinational one-hot-or-zero grant
//   rvalid   : registered one-hot read-return strobe
//   rdata    : shared read-return data
//   ram_wr   : RAM write enable
//   ram_addr : RAM address
//   ram_din  : RAM write data
//   ram_dout : RAM registered read data (1-cycle latency)
// ----------------------------------------------------------------------------
module ram_arbiter #(
    parameter int DATA      = 198,
    parameter int ADDR      = 7,
    parameter int REQS      = 3,
    parameter int MAX_BURST = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [REQS-1:0]        req,
    input  logic [REQS-1:0]        lock,
    input  logic [REQS-1:0]        wr,
    input  logic [REQS*ADDR-1:0]   addr,
    input  logic [REQS*DATA-1:0]   din,
    output logic [REQS-1:0]        gnt,
    output logic [REQS-1:0]        rvalid,
    output logic [DATA-1:0]        rdata,
    output logic                   ram_wr,
    output logic [ADDR-1:0]        ram_addr,
    output logic [DATA-1:0]        ram_din,
    input  logic [DATA-1:0]        ram_dout
);

    localparam int            PW   = (REQS > 1) ? $clog2(REQS) : 1;
    localparam logic [PW-1:0] LAST = PW'(REQS - 1);
    localparam logic [3:0]    BMAX = 4'(MAX_BURST);

    logic [PW-1:0]   ptr_q, ptr_d;
    logic            own_q, own_d;
    logic [3:0]      bcnt_q, bcnt_d;
    logic [REQS-1:0] rvalid_q, rvalid_d;

    logic            hold;
    logic            any;
    logic [PW-1:0]   g;
    logic [PW-1:0]   cand;

    // Winner selection. The hold rule keeps the current owner. Otherwise the
    // search walks ptr+1, ptr+2, ... and wraps so that ptr itself is the last
    // candidate. This also re-grants a lone owner whose burst count is used up.
    always_comb begin
        hold = own_q && req[ptr_q] && lock[ptr_q] && (bcnt_q < BMAX);
        any  = hold;
        g    = ptr_q;
        cand = ptr_q;
        if (!hold) begin
            for (int unsigned k = 0; k < REQS; k++) begin
                cand = (cand == LAST) ? '0 : cand + 1'b1;
                if (!any && req[cand]) begin
                    any = 1'b1;
                    g   = cand;
                end
            end
        end
    end

    // Grant and RAM port drive, same cycle as the decision
    always_comb begin
        gnt      = '0;
        ram_wr   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (any) begin
            gnt[g]   = 1'b1;
            ram_wr   = wr[g];
            ram_addr = addr[g*ADDR +: ADDR];
            ram_din  = din[g*DATA +: DATA];
        end
    end

    // Next-state. The burst count only advances on a hold-rule grant. Any
    // other grant restarts the count at 1, even when the same owner wins again.
    always_comb begin
        ptr_d    = ptr_q;
        own_d    = 1'b0;
        bcnt_d   = '0;
        rvalid_d = '0;
        if (any) begin
            ptr_d = g;
            own_d = 1'b1;
            if (hold) begin
                bcnt_d = (bcnt_q < BMAX) ? bcnt_q + 4'd1 : BMAX;
            end else begin
                bcnt_d = 4'd1;
            end
            if (!wr[g]) begin
                rvalid_d[g] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q    <= LAST;
            own_q    <= 1'b0;
            bcnt_q   <= '0;
            rvalid_q <= '0;
        end else begin
            ptr_q    <= ptr_d;
            own_q    <= own_d;
            bcnt_q   <= bcnt_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// ----------------------------------------------------------------------------
// Testbench for ram_arbiter. It includes a behavioural RAM for the DUT's RAM
// port and a reference model of the arbitration rules, kept as integer
// owner/count state plus a shadow memory.
// ----------------------------------------------------------------------------
module tb_ram_arbiter;

    localparam int D  = 198;
    localparam int A  = 7;
    localparam int R  = 3;
    localparam int MB = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [R-1:0]     req, lock, wr;
    logic [R*A-1:0]   addr;
    logic [R*D-1:0]   din;
    logic [R-1:0]     gnt, rvalid;
    logic [D-1:0]     rdata;
    logic             ram_wr;
    logic [A-1:0]     ram_addr;
    logic [D-1:0]     ram_din;
    logic [D-1:0]     ram_dout;

    ram_arbiter #(.DATA(D), .ADDR(A), .REQS(R), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .wr(wr),
        .addr(addr), .din(din), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // RAM port with a registered read and 1-cycle latency
    logic [D-1:0] mem [0:(1<<A)-1];
    always @(posedge clk) begin
        if (ram_wr) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    int           m_ptr  = R - 1;
    bit           m_own  = 1'b0;
    int           m_bcnt = 0;
    logic [R-1:0] m_rv   = '0;
    logic [D-1:0] m_rdata;
    bit           m_rdata_ok = 1'b0;
    logic [D-1:0] ref_mem [0:(1<<A)-1];
    bit           ref_ok  [0:(1<<A)-1];

    // Model outputs for the current cycle
    int           e_g;
    bit           e_held;
    logic [R-1:0] exp_gnt;
    logic         exp_wr;
    logic [A-1:0] exp_addr;
    logic [D-1:0] exp_din;

    function automatic logic [R*A-1:0] rand_addr();
        logic [R*A-1:0] a;
        for (int i = 0; i < R; i++) a[i*A +: A] = A'($urandom_range(0, 7));
        return a;
    endfunction

    function automatic logic [R*D-1:0] rand_din();
        logic [R*D-1:0] d = '0;
        for (int i = 0; i < (R*D + 31) / 32; i++) d = (d << 32) | (R*D)'($urandom);
        return d;
    endfunction

    // Drive one cycle of inputs after the falling edge and evaluate the model
    task automatic apply(input logic r_n, input logic [R-1:0] rq,
                         input logic [R-1:0] lk, input logic [R-1:0] w,
                         input logic [R*A-1:0] a, input logic [R*D-1:0] d);
        @(negedge clk);
        rst_n = r_n; req = rq; lock = lk; wr = w; addr = a; din = d;
        #1;
        e_held = m_own && rq[m_ptr] && lk[m_ptr] && (m_bcnt < MB);
        e_g = -1;
        if (e_held) e_g = m_ptr;
        else begin
            for (int k = 1; k <= R; k++)
                if (e_g < 0 && rq[(m_ptr + k) % R]) e_g = (m_ptr + k) % R;
        end
        exp_gnt = '0; exp_wr = 1'b0; exp_addr = '0; exp_din = '0;
        if (e_g >= 0) begin
            exp_gnt[e_g] = 1'b1;
            exp_wr       = w[e_g];
            exp_addr     = a[e_g*A +: A];
            exp_din      = d[e_g*D +: D];
        end
    endtask

    // Rising edge: advance the model, then settle
    task automatic tick();
        @(posedge clk);
        if (e_g >= 0 && exp_wr) begin
            ref_mem[exp_addr] = exp_din;
            ref_ok[exp_addr]  = 1'b1;
        end
        if (!rst_n) begin
            m_ptr = R - 1; m_own = 1'b0; m_bcnt = 0; m_rv = '0;
        end else if (e_g >= 0) begin
            m_bcnt = e_held ? ((m_bcnt + 1 > MB) ? MB : m_bcnt + 1) : 1;
            m_ptr  = e_g;
            m_own  = 1'b1;
            m_rv   = '0;
            if (!exp_wr) begin
                m_rv[e_g]  = 1'b1;
                m_rdata    = ref_mem[exp_addr];
                m_rdata_ok = ref_ok[exp_addr];
            end
        end else begin
            m_own = 1'b0; m_bcnt = 0; m_rv = '0;
        end
        #1;
    endtask

    task automatic test_reset();
        apply(1'b0, 3'b000, 3'b000, 3'b000, '0, '0);
        tick();
        apply(1'b0, 3'b000, 3'b000, 3'b000, '0, '0);
        n_cmp++;
        if (gnt !== 3'b000) begin
            n_fail++; $display("FAIL reset_gnt_idle: got %b want 000", gnt);
        end
        tick();
        n_cmp++;
        if (rvalid !== 3'b000) begin
            n_fail++; $display("FAIL reset_rvalid: got %b want 000", rvalid);
        end
        // The grant still follows the request while reset is held
        apply(1'b0, 3'b010, 3'b000, 3'b000, rand_addr(), rand_din());
        n_cmp++;
        if (gnt !== 3'b010) begin
            n_fail++; $display("FAIL reset_gnt_comb: got %b want 010", gnt);
        end
        tick();
        n_cmp++;
        if (rvalid !== 3'b000) begin
            n_fail++; $display("FAIL reset_read_no_rvalid: got %b want 000", rvalid);
        end
    endtask

    task automatic test_round_robin();
        logic [R-1:0] tab [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
        apply(1'b0, 3'b000, 3'b000, 3'b000, '0, '0);
        tick();
        for (int k = 0; k < 4; k++) begin
            apply(1'b1, 3'b111, 3'b000, 3'b000, rand_addr(), rand_din());
            n_cmp++;
            if (gnt !== tab[k] || gnt !== exp_gnt) begin
                n_fail++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, gnt, tab[k]);
            end
            n_cmp++;
            if (ram_addr !== exp_addr) begin
                n_fail++; $display("FAIL rr_addr[%0d]: got %h want %h", k, ram_addr, exp_addr);
            end
            tick();
            n_cmp++;
            if (rvalid !== tab[k]) begin
                n_fail++; $display("FAIL rr_rvalid[%0d]: got %b want %b", k, rvalid, tab[k]);
            end
        end
    endtask

    task automatic test_write_read();
        logic [R*A-1:0] a = rand_addr();
        logic [R*D-1:0] d = rand_din();
        apply(1'b0, 3'b000, 3'b000, 3'b000, '0, '0);
        tick();
        a[0 +: A] = A'(5);
        d[0 +: D] = D'(12'hABC);
        apply(1'b1, 3'b001, 3'b000, 3'b001, a, d);
        n_cmp++;
        if (ram_wr !== 1'b1 || ram_addr !== A'(5) || ram_din !== D'(12'hABC)) begin
            n_fail++;
            $display("FAIL wr_port: got wr=%b addr=%h din=%h want wr=1 addr=05 din=abc",
                     ram_wr, ram_addr, ram_din);
        end
        tick();
        n_cmp++;
        if (rvalid !== 3'b000) begin
            n_fail++; $display("FAIL wr_no_rvalid: got %b want 000", rvalid);
        end
        a[A +: A] = A'(5);
        apply(1'b1, 3'b010, 3'b000, 3'b000, a, d);
        n_cmp++;
        if (gnt !== 3'b010 || ram_wr !== 1'b0) begin
            n_fail++; $display("FAIL rd_gnt: got gnt=%b wr=%b want gnt=010 wr=0", gnt, ram_wr);
        end
        tick();
        n_cmp++;
        if (rvalid !== 3'b010 || rdata !== D'(12'hABC)) begin
            n_fail++;
            $display("FAIL rd_return: got rvalid=%b rdata=%h want rvalid=010 rdata=abc",
                     rvalid, rdata);
        end
    endtask

    task automatic test_burst_lock();
        logic [R-1:0] tab [7] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b001, 3'b001};
        apply(1'b0, 3'b000, 3'b000, 3'b000, '0, '0);
        tick();
        for (int k = 0; k < 7; k++) begin
            apply(1'b1, 3'b011, 3'b001, 3'b000, rand_addr(), rand_din());
            n_cmp++;
            if (gnt !== tab[k] || gnt !== exp_gnt) begin
                n_fail++; $display("FAIL burst_gnt[%0d]: got %b want %b", k, gnt, tab[k]);
            end
            tick();
            n_cmp++;
            if (rvalid !== tab[k]) begin
                n_fail++; $display("FAIL burst_rvalid[%0d]: got %b want %b", k, rvalid, tab[k]);
            end
        end
    endtask

    task automatic test_single_lock();
        apply(1'b0, 3'b000, 3'b000, 3'b000, '0, '0);
        tick();
        for (int k = 0; k < 10; k++) begin
            apply(1'b1, 3'b001, 3'b001, 3'b000, rand_addr(), rand_din());
            n_cmp++;
            if (gnt !== 3'b001) begin
                n_fail++; $display("FAIL single_gnt[%0d]: got %b want 001", k, gnt);
            end
            tick();
            n_cmp++;
            if (rvalid !== 3'b001) begin
                n_fail++; $display("FAIL single_rvalid[%0d]: got %b want 001", k, rvalid);
            end
        end
    endtask

    task automatic test_reset_read();
        for (int k = 0; k < 2; k++) begin
            apply(1'b1, 3'b111, 3'b000, 3'b000, rand_addr(), rand_din());
            tick();
        end
        apply(1'b0, 3'b100, 3'b000, 3'b000, rand_addr(), rand_din());
        n_cmp++;
        if (gnt !== 3'b100) begin
            n_fail++; $display("FAIL rstrd_gnt: got %b want 100", gnt);
        end
        tick();
        n_cmp++;
        if (rvalid !== 3'b000) begin
            n_fail++; $display("FAIL rstrd_rvalid: got %b want 000", rvalid);
        end
        apply(1'b1, 3'b111, 3'b000, 3'b000, rand_addr(), rand_din());
        n_cmp++;
        if (gnt !== 3'b001) begin
            n_fail++; $display("FAIL rstrd_first: got %b want 001", gnt);
        end
        tick();
        n_cmp++;
        if (rvalid !== 3'b001) begin
            n_fail++; $display("FAIL rstrd_first_rvalid: got %b want 001", rvalid);
        end
    endtask

    task automatic test_idle();
        apply(1'b0, 3'b000, 3'b000, 3'b000, '0, '0);
        tick();
        for (int k = 0; k < 6; k++) begin
            apply(1'b1, 3'b000, R'($urandom), R'($urandom), rand_addr(), rand_din());
            n_cmp++;
            if (gnt !== 3'b000 || ram_wr !== 1'b0 || ram_addr !== '0 || ram_din !== '0) begin
                n_fail++;
                $display("FAIL idle_out[%0d]: got gnt=%b wr=%b addr=%h din=%h want all zero",
                         k, gnt, ram_wr, ram_addr, ram_din);
            end
            tick();
            n_cmp++;
            if (rvalid !== 3'b000) begin
                n_fail++; $display("FAIL idle_rvalid[%0d]: got %b want 000", k, rvalid);
            end
        end
    endtask

    task automatic test_random();
        logic [R-1:0] rq, lk;
        for (int k = 0; k < 600; k++) begin
            rq = R'($urandom) | R'($urandom);
            lk = R'($urandom) | R'($urandom);
            apply(($urandom_range(0, 39) != 0), rq, lk, R'($urandom), rand_addr(), rand_din());
            n_cmp++;
            if (gnt !== exp_gnt) begin
                n_fail++; $display("FAIL rand_gnt[%0d]: got %b want %b", k, gnt, exp_gnt);
            end
            n_cmp++;
            if (ram_wr !== exp_wr || ram_addr !== exp_addr) begin
                n_fail++;
                $display("FAIL rand_port[%0d]: got wr=%b addr=%h want wr=%b addr=%h",
                         k, ram_wr, ram_addr, exp_wr, exp_addr);
            end
            n_cmp++;
            if (ram_din !== exp_din) begin
                n_fail++; $display("FAIL rand_din[%0d]: got %h want %h", k, ram_din, exp_din);
            end
            tick();
            n_cmp++;
            if (rvalid !== m_rv) begin
                n_fail++; $display("FAIL rand_rvalid[%0d]: got %b want %b", k, rvalid, m_rv);
            end
            if (m_rv != '0 && m_rdata_ok) begin
                n_cmp++;
                if (rdata !== m_rdata) begin
                    n_fail++; $display("FAIL rand_rdata[%0d]: got %h want %h", k, rdata, m_rdata);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; req = '0; lock = '0; wr = '0; addr = '0; din = '0;
        test_reset();
        test_round_robin();
        test_write_read();
        test_burst_lock();
        test_single_lock();
        test_reset_read();
        test_idle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
